// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a per-register busy
// scoreboard for pending writebacks. Reads are registered (1-cycle latency),
// register 0 is hardwired to zero.
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data
// to colliding reads; when undefined, a colliding read returns the old value.
module reg_file_mp #(
    parameter int D_WIDTH  = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*D_WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*AW-1:0]       wr_addr,
    input  logic [NUM_WR*D_WIDTH-1:0]  wr_data,
    input  logic                       alloc_en,
    input  logic [AW-1:0]              alloc_addr,
    output logic [NUM_REGS-1:0]        busy_vec
);

    logic [D_WIDTH-1:0]  reg_array [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Scoreboard update: writes retire pending writebacks, then a same-cycle
    // alloc re-marks the register busy because the newer writer wins.
    always_comb begin
        busy_next = busy_reg;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    // Register array writes; ports are applied in ascending order so the
    // highest-index port wins an address collision. x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_array[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    reg_array[wr_addr[w*AW +: AW]] <= wr_data[w*D_WIDTH +: D_WIDTH];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]      addr;
            logic [D_WIDTH-1:0] data_sel;
            logic [D_WIDTH-1:0] data_reg;
            logic               busy_out_reg;
            logic               valid_reg;

            assign addr = rd_addr[gi*AW +: AW];

            // Select read data: array contents, optionally forwarded from a
            // same-cycle write (highest port last), with x0 forced to zero.
            always_comb begin
                data_sel = reg_array[addr];
`ifdef REG_FILE_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                        data_sel = wr_data[w*D_WIDTH +: D_WIDTH];
                    end
                end
`else
                data_sel = reg_array[addr];
`endif
                if (addr == '0) begin
                    data_sel = '0;
                end
            end

            // Registered read port: data/busy hold when idle, valid pulses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg     <= '0;
                    busy_out_reg <= 1'b0;
                    valid_reg    <= 1'b0;
                end else begin
                    valid_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        data_reg     <= data_sel;
                        busy_out_reg <= busy_next[addr];
                    end
                end
            end

            assign rd_data[gi*D_WIDTH +: D_WIDTH] = data_reg;
            assign rd_busy[gi]                    = busy_out_reg;
            assign rd_valid[gi]                   = valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp (2 read, 2 write ports).
// Expected read results are computed from a behavioural model when a cycle's
// stimulus is driven, queued, and compared after the clock edge.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_valid;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [NR-1:0]     busy_vec;

    reg_file_mp #(.D_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        valid;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [NR];
    logic [31:0] m_busy;
    logic [31:0] m_rd_data [NRD];
    logic        m_rd_busy [NRD];
    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            m_rd_data[p] = '0;
            m_rd_busy[p] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic do_read(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic do_write(input int w, input int a, input logic [31:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*AW +: AW] = AW'(a);
        wr_data[w*DW +: DW] = d;
    endtask

    task automatic do_alloc(input int a);
        alloc_en = 1'b1;
        alloc_addr = AW'(a);
    endtask

    // One clock cycle: predict, queue, clock, compare, then idle the inputs.
    task automatic step(input string tag);
        logic [31:0]   bn;
        logic [31:0]   d;
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        exp_t          e;
        bn = m_busy;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w]) bn[wr_addr[w*AW +: AW]] = 1'b0;
        if (alloc_en) bn[alloc_addr] = 1'b1;
        bn[0] = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*AW +: AW];
                d = m_regs[a];
`ifdef REG_FILE_BYPASS_EN
                for (int w = 0; w < NWR; w++)
                    if (wr_en[w] && wr_addr[w*AW +: AW] == a) d = wr_data[w*DW +: DW];
`endif
                if (a == 0) d = '0;
                m_rd_data[p] = d;
                m_rd_busy[p] = bn[a];
            end
            e.port = p; e.valid = rd_en[p]; e.data = m_rd_data[p]; e.busy = m_rd_busy[p];
            exp_q.push_back(e);
        end
        for (int w = 0; w < NWR; w++) begin
            wa = wr_addr[w*AW +: AW];
            if (wr_en[w] && wa != 0) m_regs[wa] = wr_data[w*DW +: DW];
        end
        m_busy = bn;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s.p%0d.valid", tag, e.port), 32'(rd_valid[e.port]), 32'(e.valid));
            check_val($sformatf("%s.p%0d.data", tag, e.port), rd_data[e.port*DW +: DW], e.data);
            check_val($sformatf("%s.p%0d.busy", tag, e.port), 32'(rd_busy[e.port]), 32'(e.busy));
        end
        check_val($sformatf("%s.busy_vec", tag), busy_vec, m_busy);
        step_no++;
        $display("step %0d %s: rd_valid=%b rd0=0x%08h rd1=0x%08h rd_busy=%b busy_vec=0x%08h",
                 step_no, tag, rd_valid, rd_data[0 +: DW], rd_data[DW +: DW], rd_busy, busy_vec);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.rd0", rd_data[0 +: DW], 32'h0);
        check_val("reset.rd1", rd_data[DW +: DW], 32'h0);
        check_val("reset.valid", 32'(rd_valid), 32'h0);
        check_val("reset.busy_vec", busy_vec, 32'h0);
        rst_n = 1'b1;

        // Basic write then 1-cycle read latency.
        do_write(0, 5, 32'hDEADBEEF); step("wr_x5");
        do_read(0, 5);                step("rd_x5");
        step("idle_hold");

        // x0 is hardwired zero and never busy.
        do_write(0, 0, 32'h1234); do_alloc(0); do_read(0, 0); do_read(1, 0); step("x0_all");
        do_read(0, 0); do_read(1, 0); step("x0_read");

        // Dual write collision: higher port wins.
        do_write(0, 7, 32'h11); do_write(1, 7, 32'h22); step("wr2_x7");
        do_read(1, 7); step("rd_x7");

        // Read/write collision.
        do_write(0, 3, 32'hA); step("wr_x3_a");
        do_read(0, 3); do_write(0, 3, 32'hB); step("rdwr_x3");
        do_read(0, 3); do_read(1, 3); step("rd_x3");

        // Scoreboard.
        do_alloc(9); step("alloc_x9");
        do_read(1, 9); step("rd_x9_busy");
        do_alloc(9); do_write(1, 9, 32'h99); do_read(0, 9); step("alloc_wr_x9");
        do_write(0, 9, 32'h9A); do_read(1, 9); step("wr_x9");
        do_read(0, 9); step("rd_x9_free");
        do_write(1, 12, 32'hC); step("wr_nonbusy");

        // Randomised traffic over a small address window.
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 1) == 1) do_read(p, $urandom_range(0, 7));
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0) do_write(w, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 2) == 0) do_alloc($urandom_range(0, 7));
            step($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-stream.
        do_alloc(4); do_write(0, 5, 32'h55); step("pre_rst_a");
        do_alloc(6); do_read(0, 5); do_read(1, 4); step("pre_rst_b");
        do_read(0, 5); do_read(1, 6); do_alloc(8);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst.rd0", rd_data[0 +: DW], 32'h0);
        check_val("arst.rd1", rd_data[DW +: DW], 32'h0);
        check_val("arst.valid", 32'(rd_valid), 32'h0);
        check_val("arst.busy", 32'(rd_busy), 32'h0);
        check_val("arst.busy_vec", busy_vec, 32'h0);
        clear_inputs();
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_idle");
        do_read(0, 5); step("post_rst_x5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
